laser_shot_ctrl: RTL and testbench
==================================

// Module: laser_shot_ctrl
// PURPOSE
//  Owns the single player laser shot. Fires on a space-bar edge and launches the
//  shot at the cannon position. Each frame, erases the shot, moves it up and redraws it.
//  Serialises the erase and draw passes into one pixel per cycle on the VGA plot port.
//  Retires the shot at the screen top or on a collision hit. Sits between the keyboard/cannon logic and the VGA adapter.
// PARAMETERS
//  LASER_W   5        laser width in pixels (horizontal run, offsets 0..LASER_W-1)
//  X_MAX     159      last valid screen column
//  Y_START   112      row where a new shot is first drawn
//  Y_TOP     0        shot is retired once its row would go below this
//  STEP      2        rows moved per frame_tick
//  COL_LASER 3'b100   draw colour; COL_BG 3'b000 erase colour
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  space      in   1  fire key, level, already synchronised to clk
//  cannon_x   in   8  left column of cannon muzzle, sampled at launch
//  frame_tick in   1  1-cycle pulse, once per frame
//  hit        in   1  1-cycle pulse: collision logic reports shot struck a target
//  x          out  8  pixel column to plot
//  y          out  7  pixel row to plot
//  colour     out  3  pixel colour
//  plot       out  1  write enable to VGA adapter, one pixel per cycle
//  shot_live  out  1  high from LAUNCH until the shot is retired
//  shot_x     out  8  current shot left column, for collision logic
//  shot_y     out  7  current shot row, for collision logic
// BEHAVIOUR
//  Reset: state=IDLE. plot=0, shot_live=0, x=0, y=0, colour=COL_BG.
//   shot_x=0, shot_y=0. pix_cnt=0; fire_edge, tick_pend and hit_pend cleared.
//  Fire detect: fire_edge = space & ~space_q. Holding space launches exactly one shot.
//   Edges are ignored when state != IDLE; there is no queueing.
//  States (registered, one transition per clk):
//   IDLE   : on fire_edge, go to LAUNCH.
//   LAUNCH : shot_x = min(cannon_x, X_MAX-LASER_W+1); shot_y = Y_START.
//            Set shot_live=1 and pix_cnt=0. Go to DRAW.
//   DRAW   : plot=1, colour=COL_LASER, x=shot_x+pix_cnt, y=shot_y.
//            pix_cnt increments each cycle. After LASER_W cycles, go to HOLD.
//   HOLD   : plot=0. If hit_pend or tick_pend is set, go to ERASE with pix_cnt=0.
//   ERASE  : Same as DRAW but colour=COL_BG; LASER_W cycles, then go to MOVE.
//   MOVE   : if hit_pend or shot_y < Y_TOP+STEP: clear shot_live, hit_pend and tick_pend; go to IDLE.
//            Otherwise: shot_y -= STEP, clear tick_pend, pix_cnt=0; go to DRAW.
//  Pending flags: frame_tick sets tick_pend in any state except IDLE/LAUNCH.
//   hit sets hit_pend only while shot_live=1.
//   Pulses arriving in DRAW/ERASE are held, not lost. Multiple ticks collapse into one.
//   Set has priority over clear in the same cycle: a tick arriving on the MOVE cycle stays pending.
//  Outputs are combinational from state/pix_cnt/shot_x/shot_y. plot is high only in DRAW/ERASE.
//   x,y are valid whenever plot=1.
//  Arithmetic: x = shot_x + pix_cnt, 8-bit; no overflow because of the launch clamp.
//   The shot_y subtract is guarded by the MOVE check, so it never wraps.
//  Pass timing: each redraw is 2*LASER_W+2 cycles (ERASE + MOVE + DRAW + HOLD entry).
//   The frame period must exceed this.
//  Reset mid-pass: the pass aborts immediately and outputs go to reset values.
//   The partially drawn pixels are not erased; the screen clear owns that.
// TESTING
//  1 Reset, cannon_x=40, space high for 10 cycles -> one launch; 5 plots (40..44,112) in COL_LASER; shot_live=1.
//  2 frame_tick x3 -> each: 5 erase plots at old y, then 5 draws at y-2; final shot_y=106.
//  3 cannon_x=158 at launch -> shot_x clamped to 155; plots at x=155..159, none beyond X_MAX.
//  4 hit pulse during a DRAW cycle -> DRAW completes, then 5 erase plots; shot_live=0 and state IDLE.
//  5 Ticks until shot_y=1 (Y_START odd variant, STEP=2) -> erase, retire; no y underflow; re-fire works.
//  6 space edge while shot_live, and reset asserted mid-ERASE -> edge ignored; reset gives plot=0, IDLE next cycle.

Source files
------------

// File: rtl/laser_shot_ctrl.sv
// Player laser shot: launches on a fire-key edge, moves up each frame, retires at the top or on a hit.
// Latency: launch draws start 2 cycles after the key edge; each redraw is erase + move + draw, one pixel per cycle.
// Backpressure: none; frame_tick/hit pulses arriving mid-pass are held as pending flags, fire edges while busy are dropped.
// Ports: clk/reset (sync, active-high); space, cannon_x, frame_tick, hit from keyboard/cannon/collision logic;
//        x, y, colour, plot to the VGA adapter; shot_live, shot_x, shot_y to the collision logic.
module laser_shot_ctrl #(
  parameter int         LASER_W   = 5,
  parameter int         X_MAX     = 159,
  parameter int         Y_START   = 112,
  parameter int         Y_TOP     = 0,
  parameter int         STEP      = 2,
  parameter logic [2:0] COL_LASER = 3'b100,
  parameter logic [2:0] COL_BG    = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       space,
  input  logic [7:0] cannon_x,
  input  logic       frame_tick,
  input  logic       hit,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       shot_live,
  output logic [7:0] shot_x,
  output logic [6:0] shot_y
);

  localparam int         CW       = (LASER_W > 1) ? $clog2(LASER_W) : 1;
  localparam logic [CW-1:0] PIX_LAST = CW'(LASER_W - 1);
  // Rightmost legal left column, so the whole run stays on screen.
  localparam logic [7:0] X_CLAMP  = 8'(X_MAX - LASER_W + 1);
  localparam logic [6:0] Y_LIM    = 7'(Y_TOP + STEP);
  localparam logic [6:0] Y_STEP   = 7'(STEP);
  localparam logic [6:0] Y_LAUNCH = 7'(Y_START);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    DRAW,
    HOLD,
    ERASE,
    MOVE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] pix_cnt_q;
  logic          space_q;
  logic          tick_pend_q;
  logic          hit_pend_q;
  logic          live_q;
  logic [7:0]    shot_x_q;
  logic [6:0]    shot_y_q;

  logic fire_edge;
  logic tick_set;
  logic hit_set;

  assign fire_edge = space & ~space_q;
  // Ticks are only meaningful once a shot is on screen.
  assign tick_set  = frame_tick && (state_q != IDLE) && (state_q != LAUNCH);
  assign hit_set   = hit && live_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      space_q     <= 1'b0;
      tick_pend_q <= 1'b0;
      hit_pend_q  <= 1'b0;
      live_q      <= 1'b0;
      shot_x_q    <= '0;
      shot_y_q    <= '0;
    end else begin
      space_q <= space;
      case (state_q)
        IDLE: begin
          if (fire_edge) state_q <= LAUNCH;
        end
        LAUNCH: begin
          shot_x_q  <= (cannon_x > X_CLAMP) ? X_CLAMP : cannon_x;
          shot_y_q  <= Y_LAUNCH;
          live_q    <= 1'b1;
          pix_cnt_q <= '0;
          state_q   <= DRAW;
        end
        DRAW: begin
          pix_cnt_q <= pix_cnt_q + 1'b1;
          if (pix_cnt_q == PIX_LAST) state_q <= HOLD;
        end
        HOLD: begin
          if (hit_pend_q || tick_pend_q) begin
            pix_cnt_q <= '0;
            state_q   <= ERASE;
          end
        end
        ERASE: begin
          pix_cnt_q <= pix_cnt_q + 1'b1;
          if (pix_cnt_q == PIX_LAST) state_q <= MOVE;
        end
        MOVE: begin
          // The row check guards the subtract, so shot_y never wraps.
          if (hit_pend_q || (shot_y_q < Y_LIM)) begin
            live_q      <= 1'b0;
            hit_pend_q  <= 1'b0;
            tick_pend_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            shot_y_q    <= shot_y_q - Y_STEP;
            tick_pend_q <= 1'b0;
            pix_cnt_q   <= '0;
            state_q     <= DRAW;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Placed after the case so a new pulse wins over a same-cycle clear.
      if (tick_set) tick_pend_q <= 1'b1;
      if (hit_set)  hit_pend_q  <= 1'b1;
    end
  end

  assign plot      = (state_q == DRAW) || (state_q == ERASE);
  assign colour    = (state_q == DRAW) ? COL_LASER : COL_BG;
  assign x         = plot ? (shot_x_q + 8'(pix_cnt_q)) : 8'd0;
  assign y         = plot ? shot_y_q : 7'd0;
  assign shot_live = live_q;
  assign shot_x    = shot_x_q;
  assign shot_y    = shot_y_q;

endmodule

// File: tb/tb_laser_shot_ctrl.sv
// Bench for laser_shot_ctrl: directed scenarios plus randomized traffic against a pass-level model.
// The model tracks phases of a shot and the queue of pixels each pass must paint.
module tb_laser_shot_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       space = 1'b0;
  logic [7:0] cannon_x = 8'd0;
  logic       frame_tick = 1'b0;
  logic       hit = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       shot_live;
  logic [7:0] shot_x;
  logic [6:0] shot_y;

  always #5 clk = ~clk;

  laser_shot_ctrl dut (
    .clk(clk), .reset(reset), .space(space), .cannon_x(cannon_x),
    .frame_tick(frame_tick), .hit(hit),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .shot_live(shot_live), .shot_x(shot_x), .shot_y(shot_y)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_PAINT = 2, PH_WAIT = 3, PH_MOVE = 4;
  int ph = PH_IDLE;
  int after = PH_WAIT;
  int mx = 0, my = 0;
  bit mlive = 0, mtick = 0, mhit = 0, mspace = 0;
  bit fe, ts, hs, nt, nh;
  int paint_q[$];
  int seen[$];

  function automatic int pk(int px, int py, int pc);
    return (px << 16) | (py << 8) | pc;
  endfunction

  function automatic void load_pass(int col);
    paint_q.delete();
    for (int i = 0; i < 5; i++) paint_q.push_back(pk(mx + i, my, col));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      ph = PH_IDLE; mx = 0; my = 0; mlive = 0; mtick = 0; mhit = 0; mspace = 0;
      paint_q.delete();
    end else begin
      fe = space && !mspace;
      ts = frame_tick && ph != PH_IDLE && ph != PH_LAUNCH;
      hs = hit && mlive;
      mspace = space;
      nt = mtick;
      nh = mhit;
      case (ph)
        PH_IDLE:   if (fe) ph = PH_LAUNCH;
        PH_LAUNCH: begin
          mx = (cannon_x > 155) ? 155 : int'(cannon_x);
          my = 112; mlive = 1;
          load_pass(4); after = PH_WAIT; ph = PH_PAINT;
        end
        PH_PAINT: begin
          void'(paint_q.pop_front());
          if (paint_q.size() == 0) ph = after;
        end
        PH_WAIT: if (mtick || mhit) begin
          load_pass(0); after = PH_MOVE; ph = PH_PAINT;
        end
        PH_MOVE: begin
          if (mhit || my < 2) begin
            mlive = 0; nt = 0; nh = 0; ph = PH_IDLE;
          end else begin
            my = my - 2; nt = 0;
            load_pass(4); after = PH_WAIT; ph = PH_PAINT;
          end
        end
        default: ph = PH_IDLE;
      endcase
      if (ts) nt = 1;
      if (hs) nh = 1;
      mtick = nt;
      mhit = nh;
    end
  end

  // ---------------- checking ----------------
  function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // One cycle: compare DUT against the model away from the active edge.
  task automatic cyc();
    logic [31:0] exp_s, got_s;
    @(negedge clk);
    exp_s = {15'd0, 1'(ph == PH_PAINT), mlive, 8'(mx), 7'(my)};
    got_s = {15'd0, plot, shot_live, shot_x, shot_y};
    check("state", got_s, exp_s);
    if (ph == PH_PAINT && paint_q.size() > 0)
      check("pixel", pk(int'(x), int'(y), int'(colour)), paint_q[0]);
    if (plot === 1'b1) seen.push_back(pk(int'(x), int'(y), int'(colour)));
  endtask

  task automatic wait_plot(int col);
    int i;
    i = 0;
    while (!(plot === 1'b1 && int'(colour) == col) && i < 60) begin
      cyc();
      i++;
    end
    check("wait_plot", 32'(i < 60), 32'd1);
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns;
    // Reset values
    repeat (3) cyc();
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_live", 32'(shot_live), 32'd0);
    check("rst_xy", {17'd0, x, y}, 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    reset = 1'b0;
    cyc();

    // Held space launches exactly one shot at cannon_x=40
    seen.delete();
    cannon_x = 8'd40;
    space = 1'b1;
    repeat (10) cyc();
    space = 1'b0;
    repeat (5) cyc();
    check("launch_count", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      check("launch_pix", seen[i], pk(40 + i, 112, 4));
    check("launch_live", 32'(shot_live), 32'd1);

    // Three frames: erase at old row, draw two rows up
    seen.delete();
    repeat (3) begin
      tick_pulse();
      repeat (19) cyc();
    end
    check("move_y", 32'(shot_y), 32'd106);
    check("move_count", 32'(seen.size()), 32'd30);
    if (seen.size() >= 10) begin
      check("move_erase0", seen[0], pk(40, 112, 0));
      check("move_draw0", seen[5], pk(40, 110, 4));
    end

    // Hit during a draw: draw finishes, erase, retire
    tick_pulse();
    wait_plot(4);
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    repeat (20) cyc();
    check("hit_live", 32'(shot_live), 32'd0);
    ns = seen.size();
    if (ns >= 5)
      for (int i = 0; i < 5; i++)
        check("hit_erase", seen[ns - 5 + i], pk(40 + i, 104, 0));

    // Clamp at the right edge
    cannon_x = 8'd158;
    space = 1'b1;
    repeat (12) cyc();
    check("clamp_x", 32'(shot_x), 32'd155);
    ns = seen.size();
    if (ns >= 5)
      for (int i = 0; i < 5; i++)
        check("clamp_pix", seen[ns - 5 + i], pk(155 + i, 112, 4));

    // Fire edge while live is ignored; reset mid-erase aborts the pass
    space = 1'b0;
    cyc();
    space = 1'b1;
    repeat (3) cyc();
    check("busy_fire_y", 32'(shot_y), 32'd112);
    tick_pulse();
    wait_plot(0);
    cyc();
    reset = 1'b1;
    cyc();
    check("midrst_plot", 32'(plot), 32'd0);
    check("midrst_live", 32'(shot_live), 32'd0);
    reset = 1'b0;
    space = 1'b0;
    cyc();

    // Fly to the top row and retire, then re-fire
    seen.delete();
    space = 1'b1;
    repeat (10) cyc();
    space = 1'b0;
    repeat (60) begin
      tick_pulse();
      repeat (15) cyc();
    end
    check("top_live", 32'(shot_live), 32'd0);
    check("top_count", 32'(seen.size()), 32'd570);
    if (seen.size() > 0) check("top_last", seen[seen.size() - 1], pk(159, 0, 0));
    space = 1'b1;
    repeat (10) cyc();
    check("refire_live", 32'(shot_live), 32'd1);
    check("refire_y", 32'(shot_y), 32'd112);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) space = ~space;
      cannon_x   = 8'($urandom_range(0, 255));
      frame_tick = ($urandom_range(0, 11) == 0);
      hit        = ($urandom_range(0, 29) == 0);
      reset      = ($urandom_range(0, 399) == 0);
      cyc();
    end
    reset = 1'b0;
    frame_tick = 1'b0;
    hit = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
